// File: rtl/instr_fetch_decode.sv
// Fetch/decode sequencer for a 27-bit instruction ROM.
// The PC drives the ROM address and the returned word is captured into IR.
// IR is then split into op/flag/register/immediate fields, which are offered
// to the execute stage over a valid/ready handshake.
// Sequencing halts on a word with bit 0 clear, or after issuing the word at
// the top of the address space.
module instr_fetch_decode #(
   parameter logic [15:0] START_ADDR = 16'h0000,
   parameter int          COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   output logic [15:0]        rom_addr,
   input  logic [26:0]        rom_data,
   output logic               issue_valid,
   input  logic               issue_ready,
   output logic [2:0]         op,
   output logic               op_flag,
   output logic [1:0]         src_a,
   output logic [1:0]         src_b,
   output logic [1:0]         dst,
   output logic [15:0]        imm,
   output logic               busy,
   output logic               halted,
   output logic [COUNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_ISSUE  = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
   localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [15:0]          pc_q, pc_d;
   logic [26:0]          ir_q, ir_d;
   logic [2:0]           op_q, op_d;
   logic                 flag_q, flag_d;
   logic [1:0]           src_a_q, src_a_d;
   logic [1:0]           src_b_q, src_b_d;
   logic [1:0]           dst_q, dst_d;
   logic [15:0]          imm_q, imm_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic                 halted_q, halted_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 go_s;
   logic                 handshake_s;

   // Saturating increment used for the issue counter.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      if (v == COUNT_MAX) begin
         return v;
      end else begin
         return v + COUNT_ONE;
      end
   endfunction

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      op_d        = op_q;
      flag_d      = flag_q;
      src_a_d     = src_a_q;
      src_b_d     = src_b_q;
      dst_d       = dst_q;
      imm_d       = imm_q;
      count_d     = count_q;
      go_s        = start && !stop;
      handshake_s = valid_q && issue_ready;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (go_s) begin
               pc_d    = START_ADDR;
               count_d = '0;
               state_d = S_FETCH;
            end else begin
               state_d = state_q;
            end
         end
         S_FETCH: begin
            if (stop) begin
               state_d = S_IDLE;
            end else begin
               ir_d    = rom_data;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (ir_q[0] == 1'b0) begin
               state_d = S_HALT;
            end else begin
               op_d    = ir_q[26:24];
               flag_d  = ir_q[23];
               src_a_d = ir_q[22:21];
               src_b_d = ir_q[20:19];
               dst_d   = ir_q[18:17];
               imm_d   = ir_q[16:1];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (handshake_s) begin
               // A handshake coinciding with stop still completes and is counted;
               // the PC is held so sequencing can be inspected where it stopped.
               count_d = sat_inc(count_q);
               if (stop) begin
                  state_d = S_IDLE;
               end else if (pc_q == 16'hFFFF) begin
                  state_d = S_HALT;
               end else begin
                  pc_d    = pc_q + 16'd1;
                  state_d = S_FETCH;
               end
            end else if (stop) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ISSUE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered so they track the state they describe.
      valid_d  = (state_d == S_ISSUE);
      busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_ISSUE);
      halted_d = (state_d == S_HALT);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= START_ADDR;
         ir_q     <= 27'd0;
         op_q     <= 3'd0;
         flag_q   <= 1'b0;
         src_a_q  <= 2'd0;
         src_b_q  <= 2'd0;
         dst_q    <= 2'd0;
         imm_q    <= 16'd0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         op_q     <= op_d;
         flag_q   <= flag_d;
         src_a_q  <= src_a_d;
         src_b_q  <= src_b_d;
         dst_q    <= dst_d;
         imm_q    <= imm_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         halted_q <= halted_d;
         count_q  <= count_d;
      end
   end

   assign rom_addr    = pc_q;
   assign issue_valid = valid_q;
   assign op          = op_q;
   assign op_flag     = flag_q;
   assign src_a       = src_a_q;
   assign src_b       = src_b_q;
   assign dst         = dst_q;
   assign imm         = imm_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a 9-word program, stalls, stop
// handling, top-of-address-space halt and asynchronous reset mid-issue.
module tb_instr_fetch_decode;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0, ready = 1'b1;
   logic [15:0] rom_addr;
   logic [26:0] rom_data;
   logic        iv, flag, busy, halted;
   logic [2:0]  op;
   logic [1:0]  sa, sb, dd;
   logic [15:0] imm, cnt;

   logic        start2 = 1'b0, ready2 = 1'b1;
   logic [15:0] rom_addr2, imm2, cnt2;
   logic [26:0] rom_data2;
   logic        iv2, flag2, busy2, halted2;
   logic [2:0]  op2;
   logic [1:0]  sa2, sb2, dd2;

   int n_cmp = 0;
   int n_err = 0;
   logic saw_addr9 = 1'b0;

   // Expected field tables for the 9-word program at addresses 0..8.
   logic [2:0]  e_op   [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
   logic        e_flag [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [1:0]  e_a    [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [1:0]  e_b    [9] = '{2'd0, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd1};
   logic [1:0]  e_d    [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
   logic [15:0] e_imm  [9] = '{16'h000A, 16'h0005, 16'h1234, 16'hBEEF, 16'h0001,
                               16'h0077, 16'h8000, 16'hFFFF, 16'h4321};

   function automatic logic [26:0] rom_word(input logic [15:0] a);
      if (a < 16'd9)
         return {e_op[a], e_flag[a], e_a[a], e_b[a], e_d[a], e_imm[a], 1'b1};
      else if (a == 16'hFFFF)
         return {3'd7, 1'b1, 2'd1, 2'd1, 2'd1, 16'hCAFE, 1'b1};
      else
         return 27'd0;
   endfunction

   assign rom_data  = rom_word(rom_addr);
   assign rom_data2 = rom_word(rom_addr2);

   always #5 clk = ~clk;

   instr_fetch_decode #(.START_ADDR(16'h0000), .COUNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .rom_addr(rom_addr),
      .rom_data(rom_data), .issue_valid(iv), .issue_ready(ready), .op(op),
      .op_flag(flag), .src_a(sa), .src_b(sb), .dst(dd), .imm(imm),
      .busy(busy), .halted(halted), .instr_count(cnt));

   instr_fetch_decode #(.START_ADDR(16'hFFFF), .COUNT_W(16)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .stop(1'b0), .rom_addr(rom_addr2),
      .rom_data(rom_data2), .issue_valid(iv2), .issue_ready(ready2), .op(op2),
      .op_flag(flag2), .src_a(sa2), .src_b(sb2), .dst(dd2), .imm(imm2),
      .busy(busy2), .halted(halted2), .instr_count(cnt2));

   // Flags any issue offered for the invalid word at address 9.
   always @(negedge clk) begin
      if (iv && rom_addr == 16'd9) saw_addr9 <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_valid(input int which, input string tag);
      int n = 0;
      while (((which == 0) ? iv : iv2) !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(tag, (which == 0) ? iv : iv2, 1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      chk("rst_addr", rom_addr, 16'h0000);
      chk("rst_valid", iv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_addr2", rom_addr2, 16'hFFFF);
      rst = 1'b0;
      step();

      // Latency: FETCH, DECODE, then ISSUE in the third cycle after start.
      ready = 1'b1;
      pulse_start();
      chk("lat_fetch_busy", busy, 1);
      chk("lat_fetch_valid", iv, 0);
      step();
      chk("lat_decode_valid", iv, 0);
      step();
      chk("lat_issue_valid", iv, 1);
      chk("w0_op", op, 0);
      chk("w0_src_a", sa, 0);
      chk("w0_dst", dd, 0);
      chk("w0_imm", imm, 16'h000A);
      step();
      chk("w0_addr_adv", rom_addr, 1);
      chk("w0_cnt", cnt, 1);

      // Remaining program words.
      for (int k = 1; k < 9; k++) begin
         wait_valid(0, "prog_valid");
         chk("prog_addr", rom_addr, k);
         chk("prog_op", op, e_op[k]);
         chk("prog_flag", flag, e_flag[k]);
         chk("prog_src_a", sa, e_a[k]);
         chk("prog_src_b", sb, e_b[k]);
         chk("prog_dst", dd, e_d[k]);
         chk("prog_imm", imm, e_imm[k]);
         step();
      end
      for (int n = 0; n < 10 && halted !== 1'b1; n++) @(negedge clk);
      chk("prog_halted", halted, 1);
      chk("prog_cnt", cnt, 9);
      chk("prog_no_addr9", saw_addr9, 0);
      chk("prog_busy", busy, 0);

      // Stall in ISSUE with ready low, restarting from HALT.
      ready = 1'b0;
      pulse_start();
      chk("restart_cnt_clr", cnt, 0);
      wait_valid(0, "stall_valid");
      for (int n = 0; n < 5; n++) begin
         step();
         chk("stall_valid_hold", iv, 1);
         chk("stall_imm_hold", imm, 16'h000A);
         chk("stall_addr_hold", rom_addr, 0);
         chk("stall_cnt_hold", cnt, 0);
      end
      ready = 1'b1;
      step();
      chk("stall_release_cnt", cnt, 1);
      chk("stall_release_valid", iv, 0);

      // Now in FETCH for addr 1; one cycle later DECODE, where stop is applied.
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stopdec_busy", busy, 0);
      chk("stopdec_valid", iv, 0);
      chk("stopdec_addr", rom_addr, 1);
      chk("stopdec_cnt", cnt, 1);
      step();
      step();
      chk("stopdec_still_idle", busy, 0);

      // Stop together with the handshake: counted, then IDLE.
      ready = 1'b0;
      pulse_start();
      wait_valid(0, "stophs_valid");
      stop = 1'b1;
      ready = 1'b1;
      step();
      stop = 1'b0;
      chk("stophs_cnt", cnt, 1);
      chk("stophs_busy", busy, 0);
      chk("stophs_valid", iv, 0);

      // start and stop together while idle: stop wins.
      start = 1'b1;
      stop = 1'b1;
      step();
      start = 1'b0;
      stop = 1'b0;
      chk("startstop_busy", busy, 0);

      // Top of address space on the second instance.
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      wait_valid(1, "top_valid");
      chk("top_imm", imm2, 16'hCAFE);
      chk("top_addr", rom_addr2, 16'hFFFF);
      step();
      chk("top_halted", halted2, 1);
      chk("top_addr_held", rom_addr2, 16'hFFFF);
      chk("top_cnt", cnt2, 1);
      chk("top_valid_drop", iv2, 0);

      // Asynchronous reset while an issue is pending.
      ready = 1'b1;
      pulse_start();
      wait_valid(0, "rstmid_first");
      step();
      ready = 1'b0;
      wait_valid(0, "rstmid_second");
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_valid", iv, 0);
      chk("rstmid_cnt", cnt, 0);
      chk("rstmid_addr", rom_addr, 0);
      chk("rstmid_imm", imm, 0);
      chk("rstmid_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Fetch/decode sequencer that reads the 27-bit instruction ROM.
- Drives the ROM address from a program counter and captures the returned word.
- Splits the word into opcode/flag/register/immediate fields and presents them to the execute stage over a valid/ready handshake.
- Halts on an invalid word (bit 0 clear) or on reaching the top of the address space.

Parameters:
- START_ADDR, 16'h0000, PC value loaded on reset and on every start.
- COUNT_W, 16, width of the saturating issued-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin fetching from START_ADDR; honoured only in IDLE or HALT
- stop  in  1  abort sequencing, return to IDLE
- rom_addr  out  16  ROM address, registered, always equals PC
- rom_data  in  27  ROM word (combinational ROM, valid in the same cycle as rom_addr)
- issue_valid  out  1  decoded instruction available
- issue_ready  in  1  execute stage accepts the instruction
- op  out  3  rom_data[26:24]
- op_flag  out  1  rom_data[23]
- src_a  out  2  rom_data[22:21]
- src_b  out  2  rom_data[20:19]
- dst  out  2  rom_data[18:17]
- imm  out  16  rom_data[16:1]
- busy  out  1  state is FETCH, DECODE or ISSUE
- halted  out  1  state is HALT
- instr_count  out  COUNT_W  number of completed issue handshakes, saturating

Behaviour:
- Reset (async): state=IDLE; PC=START_ADDR; IR=0; all outputs 0; rom_addr=START_ADDR.
- IDLE:
  - start=1 -> PC<=START_ADDR, instr_count<=0, go to FETCH.
  - stop has no effect.
- FETCH:
  - rom_addr=PC.
  - IR<=rom_data at the clock edge; go to DECODE.
- DECODE:
  - IR[0]==0 -> go to HALT; nothing is issued.
  - Otherwise register op/op_flag/src_a/src_b/dst/imm from IR; go to ISSUE.
- ISSUE:
  - issue_valid=1; all field outputs are held stable until the handshake.
  - issue_valid && issue_ready -> instr_count+1 (saturating at all-ones).
    - If PC==16'hFFFF -> go to HALT; PC is not incremented.
    - Otherwise PC<=PC+1 and go to FETCH.
- HALT:
  - issue_valid=0; fields retain their last values.
  - start=1 -> behaves as in IDLE (PC reload, counter clear, go to FETCH).
- Latency:
  - start sampled at edge N -> FETCH in cycle N+1, DECODE N+2, issue_valid=1 in N+3.
  - Steady state with issue_ready tied high: one instruction per 3 cycles.
- stop:
  - In FETCH/DECODE/ISSUE, stop=1 -> IDLE next cycle; issue_valid drops; PC is held.
  - stop together with an ISSUE handshake: the handshake completes (counter increments) and the next state is IDLE.
  - In HALT, stop -> IDLE.
- start while busy is ignored; start and stop together in IDLE/HALT: stop wins, state is IDLE.
- Reset mid-operation: immediate return to reset values. Any pending issue is dropped, not counted.
- issue_valid never deasserts without a handshake except on stop or reset.

Test Plan:
- Reset, start pulse, issue_ready=1, ROM[0]=0x000_0_00_00_00_000A_1 -> issue_valid in cycle 3 after start; op=0, src_a=0, dst=0, imm=16'h000A; rom_addr advances to 1.
- Next word 000_0_01_00_01_0005_1 -> op=0, src_a=1, src_b=0, dst=1, imm=16'h0005, op_flag=0; word 100_1_01_00_00_..._1 at addr 5 -> op=4, op_flag=1.
- Run the 9-word program then default word 0 at addr 9 -> 9 issues, instr_count=9, halted=1, issue_valid never asserted for addr 9.
- Hold issue_ready=0 for 5 cycles in ISSUE -> issue_valid and all fields stable, PC unchanged, count unchanged; raise ready -> exactly one increment.
- stop asserted in DECODE -> IDLE next cycle, busy=0, no issue; stop together with the handshake -> count+1, then IDLE.
- START_ADDR=16'hFFFF with a valid word -> one issue then HALT with rom_addr still 16'hFFFF; assert rst mid-ISSUE -> all outputs 0 asynchronously.
